// File: rtl/wb_gpio_bank.sv
// Wishbone-slave GPIO bank: NUM_PINS pins with output enables, synchronised inputs,
// rising/falling edge capture with W1C status and interrupts. Define GPIO_DEBOUNCE_EN for the input debouncer.
`timescale 1ns/1ps
module wb_gpio_bank #(
    parameter int unsigned NUM_PINS  = 16,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_ni,
    input  logic                wbs_cyc_i,
    input  logic                wbs_stb_i,
    input  logic                wbs_we_i,
    input  logic [3:0]          wbs_sel_i,
    input  logic [31:0]         wbs_adr_i,
    input  logic [31:0]         wbs_dat_i,
    output logic [31:0]         wbs_dat_o,
    output logic                wbs_ack_o,
    input  logic [NUM_PINS-1:0] io_in,
    output logic [NUM_PINS-1:0] io_out,
    output logic [NUM_PINS-1:0] io_oeb,
    output logic [2:0]          irq
);

    localparam logic [3:0] REG_OUT       = 4'h0;
    localparam logic [3:0] REG_OEB       = 4'h1;
    localparam logic [3:0] REG_IN        = 4'h2;
    localparam logic [3:0] REG_RISE_EN   = 4'h3;
    localparam logic [3:0] REG_FALL_EN   = 4'h4;
    localparam logic [3:0] REG_RISE_STAT = 4'h5;
    localparam logic [3:0] REG_FALL_STAT = 4'h6;
    localparam logic [3:0] REG_DEBOUNCE  = 4'h7;

    logic [NUM_PINS-1:0] out_q, oeb_q, rise_en_q, fall_en_q;
    logic [NUM_PINS-1:0] rise_stat_q, fall_stat_q;
    logic [NUM_PINS-1:0] sync1_q, sync2_q, in_q, prev_q;
    logic [NUM_PINS-1:0] rise_evt, fall_evt, rise_clr, fall_clr;
    logic [NUM_PINS-1:0] wr_bits, wr_mask;
    logic [31:0]         lane_mask, rdata;
    logic [3:0]          reg_idx;
    logic                hit, req, wr_en;
    logic                unused_bits;

    assign hit       = (wbs_adr_i[31:6] == BASE_ADDR[31:6]);
    assign req       = wbs_cyc_i & wbs_stb_i & hit & ~wbs_ack_o;
    assign wr_en     = req & wbs_we_i;
    assign reg_idx   = wbs_adr_i[5:2];
    assign lane_mask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
    assign wr_bits   = wbs_dat_i[NUM_PINS-1:0];
    assign wr_mask   = lane_mask[NUM_PINS-1:0];
    assign unused_bits = ^{wbs_adr_i[1:0], wbs_dat_i, lane_mask};

    function automatic logic [NUM_PINS-1:0] merge(input logic [NUM_PINS-1:0] old_v,
                                                  input logic [NUM_PINS-1:0] new_v,
                                                  input logic [NUM_PINS-1:0] mask);
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    // Only bytes selected by wbs_sel_i may clear status bits.
    assign rise_clr = (wr_en && reg_idx == REG_RISE_STAT) ? (wr_bits & wr_mask) : '0;
    assign fall_clr = (wr_en && reg_idx == REG_FALL_STAT) ? (wr_bits & wr_mask) : '0;
    assign rise_evt = in_q & ~prev_q & rise_en_q;
    assign fall_evt = ~in_q & prev_q & fall_en_q;

`ifdef GPIO_DEBOUNCE_EN
    logic [15:0]         debounce_q, presc_q;
    logic [NUM_PINS-1:0] hist0_q, hist1_q, agree;
    logic                tick, wr_debounce;

    assign wr_debounce = wr_en && reg_idx == REG_DEBOUNCE;
    assign tick        = (presc_q == debounce_q);
    assign agree       = ~(sync2_q ^ hist0_q) & ~(hist0_q ^ hist1_q);

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            debounce_q <= '0;
            presc_q    <= '0;
            hist0_q    <= '0;
            hist1_q    <= '0;
            in_q       <= '0;
        end else begin
            if (wr_debounce) begin
                debounce_q <= (debounce_q & ~lane_mask[15:0]) | (wbs_dat_i[15:0] & lane_mask[15:0]);
                presc_q    <= '0;
            end else if (tick) begin
                presc_q    <= '0;
            end else begin
                presc_q    <= presc_q + 16'd1;
            end
            // A pin's level is accepted only when the current and two previous tick samples agree.
            if (tick) begin
                hist0_q <= sync2_q;
                hist1_q <= hist0_q;
                in_q    <= (in_q & ~agree) | (sync2_q & agree);
            end
        end
    end
`else
    assign in_q = sync2_q;
`endif

    always_comb begin
        // NOTE: default assignment first so every path drives rdata and no latch is inferred.
        rdata = '0;
        case (reg_idx)
            REG_OUT:       rdata[NUM_PINS-1:0] = out_q;
            REG_OEB:       rdata[NUM_PINS-1:0] = oeb_q;
            REG_IN:        rdata[NUM_PINS-1:0] = in_q;
            REG_RISE_EN:   rdata[NUM_PINS-1:0] = rise_en_q;
            REG_FALL_EN:   rdata[NUM_PINS-1:0] = fall_en_q;
            REG_RISE_STAT: rdata[NUM_PINS-1:0] = rise_stat_q;
            REG_FALL_STAT: rdata[NUM_PINS-1:0] = fall_stat_q;
`ifdef GPIO_DEBOUNCE_EN
            REG_DEBOUNCE:  rdata[15:0]         = debounce_q;
`endif
            default:       rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        // NOTE: every flop here has an async reset value; no register is left to power-up state.
        if (!wb_rst_ni) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            out_q     <= '0;
            oeb_q     <= '1;
            rise_en_q <= '0;
            fall_en_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so all state updates from pre-edge values.
            wbs_ack_o <= req;
            if (req) wbs_dat_o <= rdata;
            if (wr_en && reg_idx == REG_OUT)     out_q     <= merge(out_q, wr_bits, wr_mask);
            if (wr_en && reg_idx == REG_OEB)     oeb_q     <= merge(oeb_q, wr_bits, wr_mask);
            if (wr_en && reg_idx == REG_RISE_EN) rise_en_q <= merge(rise_en_q, wr_bits, wr_mask);
            if (wr_en && reg_idx == REG_FALL_EN) fall_en_q <= merge(fall_en_q, wr_bits, wr_mask);
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            prev_q      <= '0;
            rise_stat_q <= '0;
            fall_stat_q <= '0;
        end else begin
            sync1_q     <= io_in;
            sync2_q     <= sync1_q;
            prev_q      <= in_q;
            // A new event wins over a same-cycle clear of the same bit.
            rise_stat_q <= (rise_stat_q & ~rise_clr) | rise_evt;
            fall_stat_q <= (fall_stat_q & ~fall_clr) | fall_evt;
        end
    end

    assign io_out = out_q;
    assign io_oeb = oeb_q;
    assign irq[0] = |rise_stat_q;
    assign irq[1] = |fall_stat_q;
    assign irq[2] = irq[0] | irq[1];

endmodule

// File: tb/tb_wb_gpio_bank.sv
// Self-checking bench for wb_gpio_bank (NUM_PINS=16): directed vectors, corner sequences,
// and randomized traffic against a register/pin-level reference model.
`timescale 1ns/1ps
module tb_wb_gpio_bank;

    localparam logic [31:0] BASE = 32'h3000_0000;
`ifdef GPIO_DEBOUNCE_EN
    localparam int          EDGE_LAT = 5;
    localparam logic [31:0] DEB_RB   = 32'h0000_2345;
`else
    localparam int          EDGE_LAT = 2;
    localparam logic [31:0] DEB_RB   = 32'h0000_0000;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = '0, dat_i = '0, dat_o;
    logic        ack;
    logic [15:0] io_in = '0, io_out, io_oeb;
    logic [2:0]  irq;

    int n_cmp = 0;
    int n_bad = 0;

    wb_gpio_bank #(.NUM_PINS(16), .BASE_ADDR(BASE)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(dat_i), .wbs_dat_o(dat_o), .wbs_ack_o(ack),
        .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  off;
        logic [31:0] wdata;
        logic [3:0]  sel;
        logic [31:0] exp_rd;
        logic [15:0] exp_out;
        logic [15:0] exp_oeb;
    } vec_t;

    vec_t tbl[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] lanes(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    // One transaction; lat is the ack latency in cycles, 0 if no ack within 8 cycles.
    task automatic bus(input logic w, input logic [5:0] off, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] rd, output int lat);
        cyc = 1'b1; stb = 1'b1; we = w; adr = BASE + {26'd0, off}; dat_i = d; sel = s;
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (ack) begin
                lat = i;
                break;
            end
        end
        rd = dat_o;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [5:0] off, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] rd;
        int lat;
        bus(1'b1, off, d, s, rd, lat);
        check("write ack latency", lat, 1);
    endtask

    task automatic rd_check(input string name, input logic [5:0] off, input logic [31:0] exp);
        logic [31:0] rd;
        int lat;
        bus(1'b0, off, 32'hDEAD_BEEF, 4'h0, rd, lat);
        check({name, " ack"}, lat, 1);
        check(name, rd, exp);
    endtask

    task automatic reset_pulse();
        io_in = '0;
        @(negedge clk); rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] m[16];
        logic [31:0] rd, exp, lm, d;
        logic [15:0] pins, new_pins;
        logic [3:0]  s;
        int lat, ridx, seen;
        int widx[6];

        tbl[0]  = '{6'h00, 32'hA5A5_1234, 4'b0001, 32'h0000_0034, 16'h0034, 16'hFFFF};
        tbl[1]  = '{6'h00, 32'hFFFF_FFFF, 4'b0010, 32'h0000_FF34, 16'hFF34, 16'hFFFF};
        tbl[2]  = '{6'h00, 32'h1234_5678, 4'b1100, 32'h0000_FF34, 16'hFF34, 16'hFFFF};
        tbl[3]  = '{6'h04, 32'h0000_0000, 4'b0001, 32'h0000_FF00, 16'hFF34, 16'hFF00};
        tbl[4]  = '{6'h0C, 32'hFFFF_00F0, 4'b1111, 32'h0000_00F0, 16'hFF34, 16'hFF00};
        tbl[5]  = '{6'h10, 32'h0000_ABCD, 4'b0011, 32'h0000_ABCD, 16'hFF34, 16'hFF00};
        tbl[6]  = '{6'h08, 32'h0000_FFFF, 4'b1111, 32'h0000_0000, 16'hFF34, 16'hFF00};
        tbl[7]  = '{6'h24, 32'hFFFF_FFFF, 4'b1111, 32'h0000_0000, 16'hFF34, 16'hFF00};
        tbl[8]  = '{6'h1C, 32'h0001_2345, 4'b1111, DEB_RB,        16'hFF34, 16'hFF00};
        tbl[9]  = '{6'h04, 32'h0000_5A5A, 4'b0010, 32'h0000_5A00, 16'hFF34, 16'h5A00};
        tbl[10] = '{6'h14, 32'hFFFF_FFFF, 4'b1111, 32'h0000_0000, 16'hFF34, 16'h5A00};

        // Reset state
        repeat (3) @(negedge clk);
        check("ack in reset", {31'd0, ack}, 0);
        check("io_oeb in reset", {16'd0, io_oeb}, 32'h0000_FFFF);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("irq after reset", {29'd0, irq}, 0);
        check("io_out after reset", {16'd0, io_out}, 0);
        for (int i = 0; i < 16; i++)
            rd_check($sformatf("reset read off 0x%02h", i * 4), 6'(i * 4), (i == 1) ? 32'h0000_FFFF : 32'h0);

        // Directed register vectors
        foreach (tbl[i]) begin
            wr(tbl[i].off, tbl[i].wdata, tbl[i].sel);
            check($sformatf("vec%0d io_out", i), {16'd0, io_out}, {16'd0, tbl[i].exp_out});
            check($sformatf("vec%0d io_oeb", i), {16'd0, io_oeb}, {16'd0, tbl[i].exp_oeb});
            rd_check($sformatf("vec%0d readback", i), tbl[i].off, tbl[i].exp_rd);
        end

        // Rising edge on pin 0
        reset_pulse();
        wr(6'h0C, 32'h0000_0001, 4'b1111);
        io_in[0] = 1'b1;
        repeat (EDGE_LAT) @(posedge clk);
        @(negedge clk);
        check("irq before rise lands", {29'd0, irq}, 0);
        @(posedge clk);
        @(negedge clk);
        check("irq on rise", {29'd0, irq}, 32'h5);
        rd_check("IN after rise", 6'h08, 32'h1);
        rd_check("RISE_STAT after rise", 6'h14, 32'h1);
        wr(6'h14, 32'h0000_0001, 4'b0001);
        check("irq after rise clear", {29'd0, irq}, 0);

        // Same-edge W1C and new falling edge on pin 3
        wr(6'h10, 32'h0000_0008, 4'b1111);
        io_in[3] = 1'b1;
        repeat (8) @(posedge clk); #1;
        check("irq before collision", {29'd0, irq}, 0);
        io_in[3] = 1'b0;
        repeat (EDGE_LAT) @(posedge clk); #1;
        wr(6'h18, 32'h0000_0008, 4'b0001);
        check("irq after collision", {29'd0, irq}, 32'h6);
        rd_check("FALL_STAT after collision", 6'h18, 32'h8);
        wr(6'h18, 32'h0000_0008, 4'b0001);
        rd_check("FALL_STAT after clear", 6'h18, 32'h0);

        // Address window
        bus(1'b0, 6'h00, 32'h0, 4'h0, rd, lat);
        adr = '0;
        cyc = 1'b1; stb = 1'b1; adr = BASE + 32'h40;
        seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (ack) seen = 1;
        end
        cyc = 1'b0; stb = 1'b0;
        check("ack outside window", seen, 0);
        rd_check("unmapped 0x24", 6'h24, 32'h0);

        // Reset during a transaction
        wr(6'h00, 32'h0000_00FF, 4'b1111);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE;
        @(posedge clk); #1;
        check("ack before abort", {31'd0, ack}, 1);
        rst_n = 1'b0;
        #1;
        check("ack dropped by reset", {31'd0, ack}, 0);
        check("io_out by reset", {16'd0, io_out}, 0);
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (ack) seen = 1;
        end
        check("no ack after reset release", seen, 0);

`ifdef GPIO_DEBOUNCE_EN
        // Debounce filter with a 5-cycle tick
        reset_pulse();
        wr(6'h1C, 32'h0000_0004, 4'b0011);
        wr(6'h0C, 32'h0000_0004, 4'b1111);
        io_in[2] = 1'b1;
        repeat (3) @(posedge clk); #1;
        io_in[2] = 1'b0;
        repeat (20) @(posedge clk); #1;
        rd_check("IN after glitch", 6'h08, 32'h0);
        rd_check("RISE_STAT after glitch", 6'h14, 32'h0);
        io_in[2] = 1'b1;
        repeat (20) @(posedge clk); #1;
        rd_check("IN after stable level", 6'h08, 32'h4);
`endif

        // Randomized traffic against the reference model
        reset_pulse();
        foreach (m[i]) m[i] = '0;
        m[1] = 32'h0000_FFFF;
        pins = '0;
        widx = '{0, 1, 3, 4, 5, 6};
        for (int it = 0; it < 80; it++) begin
            ridx = widx[$urandom_range(0, 5)];
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            lm = lanes(s) & 32'h0000_FFFF;
            if (ridx == 5 || ridx == 6) m[ridx] = m[ridx] & ~(d & lm);
            else                        m[ridx] = (m[ridx] & ~lm) | (d & lm);
            bus(1'b1, 6'(ridx * 4), d, s, rd, lat);
            check("random write ack", lat, 1);

            new_pins = (it % 3 == 0) ? pins : 16'($urandom);
            io_in = new_pins;
            m[5] = m[5] | {16'd0, new_pins & ~pins & m[3][15:0]};
            m[6] = m[6] | {16'd0, ~new_pins & pins & m[4][15:0]};
            pins = new_pins;
            repeat (8) @(posedge clk); #1;

            ridx = $urandom_range(0, 15);
            exp = (ridx == 2) ? {16'd0, pins} : m[ridx];
            rd_check($sformatf("random read off 0x%02h", ridx * 4), 6'(ridx * 4), exp);
            check("random io_out", {16'd0, io_out}, m[0]);
            check("random io_oeb", {16'd0, io_oeb}, m[1]);
            check("random irq", {29'd0, irq},
                  {29'd0, (m[5] != 0) || (m[6] != 0), m[6] != 0, m[5] != 0});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
